// File: rtl/vector_line_writer.sv
// Formats each accepted sample as one ASCII .mem line: bits MSB first, optional spaces, newline.
// First character is valid the cycle after accept; byte_ready low stalls the line with outputs held.
module vector_line_writer #(
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] SPACE_AFTER = DATA_W'(8'b1001_0000)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [DATA_W-1:0] sample_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [7:0]        byte_data,
  output logic              busy,
  output logic [15:0]       line_count
);

  localparam int               IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BIT     = 2'd1,
    SPACE   = 2'd2,
    NEWLINE = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] mask_q;
  logic [IDX_W-1:0]  idx_q;
  logic [15:0]       line_cnt_q;
  logic              sample_acc;
  logic              last_bit;
  logic              space_next;

  assign sample_acc = sample_valid && sample_ready;
  assign last_bit   = (idx_q == '0);
  // hold_q and mask_q shift together, so the bit being printed and its space flag sit at the top
  assign space_next = mask_q[DATA_W-1];
  assign line_count = line_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sample_acc) state_d = BIT;
      end
      BIT: begin
        if (byte_ready) begin
          if (last_bit)        state_d = NEWLINE;
          else if (space_next) state_d = SPACE;
          else                 state_d = BIT;
        end
      end
      SPACE: begin
        if (byte_ready) state_d = BIT;
      end
      NEWLINE: begin
        if (byte_ready) state_d = sample_acc ? BIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sample_ready = 1'b0;
    byte_valid   = 1'b0;
    byte_data    = 8'h00;
    busy         = 1'b0;
    case (state_q)
      IDLE: begin
        sample_ready = !reset;
      end
      BIT: begin
        byte_valid = 1'b1;
        busy       = 1'b1;
        byte_data  = {7'b0011000, hold_q[DATA_W-1]};
      end
      SPACE: begin
        byte_valid = 1'b1;
        busy       = 1'b1;
        byte_data  = 8'h20;
      end
      NEWLINE: begin
        // accepting the next sample on the newline cycle keeps lines back-to-back
        sample_ready = byte_ready && !reset;
        byte_valid   = 1'b1;
        busy         = 1'b1;
        byte_data    = 8'h0A;
      end
      default: begin
        sample_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q     <= '0;
      mask_q     <= '0;
      idx_q      <= '0;
      line_cnt_q <= 16'h0000;
    end else begin
      if (sample_acc) begin
        hold_q <= sample_data;
        mask_q <= SPACE_AFTER;
        idx_q  <= IDX_TOP;
      end else if ((state_q == BIT && byte_ready && !last_bit && !space_next) ||
                   (state_q == SPACE && byte_ready)) begin
        hold_q <= hold_q << 1;
        mask_q <= mask_q << 1;
        idx_q  <= idx_q - 1'b1;
      end
      if (state_q == NEWLINE && byte_ready) begin
        line_cnt_q <= line_cnt_q + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_vector_line_writer.sv
// Randomized bench for vector_line_writer: two instances (8-bit default, 1-bit) against a byte-queue model.
module tb_vector_line_writer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        sample_valid = 1'b0;
  logic        byte_ready   = 1'b0;
  logic        sel          = 1'b0;
  logic [7:0]  sample_data0 = 8'h00;
  logic        sample_data1 = 1'b0;
  logic        sv0, sv1;

  logic        sample_ready0, byte_valid0, busy0;
  logic [7:0]  byte_data0;
  logic [15:0] line_count0;
  logic        sample_ready1, byte_valid1, busy1;
  logic [7:0]  byte_data1;
  logic [15:0] line_count1;

  assign sv0 = sample_valid & ~sel;
  assign sv1 = sample_valid & sel;

  vector_line_writer dut0 (
    .clock(clock), .reset(reset),
    .sample_valid(sv0), .sample_ready(sample_ready0), .sample_data(sample_data0),
    .byte_valid(byte_valid0), .byte_ready(byte_ready), .byte_data(byte_data0),
    .busy(busy0), .line_count(line_count0)
  );

  vector_line_writer #(.DATA_W(1), .SPACE_AFTER(1'b0)) dut1 (
    .clock(clock), .reset(reset),
    .sample_valid(sv1), .sample_ready(sample_ready1), .sample_data(sample_data1),
    .byte_valid(byte_valid1), .byte_ready(byte_ready), .byte_data(byte_data1),
    .busy(busy1), .line_count(line_count1)
  );

  logic        o_srdy, o_bvld, o_busy;
  logic [7:0]  o_bdat;
  logic [15:0] o_lcnt;
  assign o_srdy = sel ? sample_ready1 : sample_ready0;
  assign o_bvld = sel ? byte_valid1   : byte_valid0;
  assign o_busy = sel ? busy1         : busy0;
  assign o_bdat = sel ? byte_data1    : byte_data0;
  assign o_lcnt = sel ? line_count1   : line_count0;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  logic [63:0] pend[$];
  logic [15:0] model_lines = 16'h0000;
  int          popped;
  int          rdy_pct = 100;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected text of one line, built straight from the formatting rule
  function automatic void push_line(input logic [63:0] d);
    int          w;
    logic [63:0] m;
    w = sel ? 1 : 8;
    m = sel ? 64'h0 : 64'h90;
    for (int i = w - 1; i >= 0; i--) begin
      exp_q.push_back(d[i] ? 8'h31 : 8'h30);
      if (i != 0 && m[i]) exp_q.push_back(8'h20);
    end
    exp_q.push_back(8'h0A);
  endfunction

  // Entered and left at posedge+1; all observation happens on the falling edge.
  task automatic run(input int max_cycles, input int stop_bytes);
    logic       prev_stall;
    logic [7:0] prev_byte;
    logic [7:0] b;
    logic       done;
    popped     = 0;
    prev_stall = 1'b0;
    prev_byte  = 8'h00;
    done       = 1'b0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      sample_valid = (pend.size() > 0);
      sample_data0 = (pend.size() > 0) ? pend[0][7:0] : 8'($urandom);
      sample_data1 = (pend.size() > 0) ? pend[0][0]   : 1'($urandom);
      byte_ready   = ($urandom_range(99) < rdy_pct);
      @(negedge clock);
      if (prev_stall) begin
        chk("stall_valid", 64'(o_bvld), 64'(1'b1));
        chk("stall_data", 64'(o_bdat), 64'(prev_byte));
      end
      chk("busy", 64'(o_busy), 64'(exp_q.size() > 0));
      chk("byte_valid", 64'(o_bvld), 64'(exp_q.size() > 0));
      chk("line_count", 64'(o_lcnt), 64'(model_lines));
      chk("sample_ready", 64'(o_srdy),
          64'(exp_q.size() == 0 || (exp_q.size() == 1 && byte_ready)));
      if (o_bvld && byte_ready && exp_q.size() > 0) begin
        b = exp_q.pop_front();
        chk("byte_data", 64'(o_bdat), 64'(b));
        popped++;
        if (b == 8'h0A) model_lines = model_lines + 16'h0001;
      end
      prev_stall = o_bvld && !byte_ready;
      prev_byte  = o_bdat;
      if (sample_valid && o_srdy) push_line(pend.pop_front());
      @(posedge clock);
      #1;
      if (stop_bytes > 0 && popped >= stop_bytes) done = 1'b1;
      if (stop_bytes == 0 && pend.size() == 0 && exp_q.size() == 0) done = 1'b1;
    end
    chk("run_completed", 64'(done), 64'(1'b1));
    sample_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_byte_valid", 64'(byte_valid0), 64'(1'b0));
    chk("rst_byte_data", 64'(byte_data0), 64'(8'h00));
    chk("rst_busy", 64'(busy0), 64'(1'b0));
    chk("rst_line_count", 64'(line_count0), 64'(16'h0000));
    chk("rst_sample_ready", 64'(sample_ready0), 64'(1'b0));
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("post_rst_ready", 64'(sample_ready0), 64'(1'b1));

    // single line, then back-to-back pair, then the same line under random backpressure
    pend.push_back(64'hD3);
    run(100, 0);
    chk("one_line_count", 64'(line_count0), 64'(16'd1));
    pend.push_back(64'hFF);
    pend.push_back(64'h00);
    run(100, 0);
    rdy_pct = 30;
    pend.push_back(64'hD3);
    run(400, 0);

    for (int k = 0; k < 20; k++) pend.push_back(64'($urandom));
    rdy_pct = 60 + $urandom_range(40);
    run(3000, 0);
    rdy_pct = 100;

    // reset in the middle of a line
    pend.push_back(64'hD3);
    run(100, 4);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_byte_valid", 64'(byte_valid0), 64'(1'b0));
    chk("midrst_line_count", 64'(line_count0), 64'(16'h0000));
    chk("midrst_busy", 64'(busy0), 64'(1'b0));
    chk("midrst_sample_ready", 64'(sample_ready0), 64'(1'b0));
    exp_q.delete();
    pend.delete();
    model_lines = 16'h0000;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    pend.push_back(64'h80);
    run(100, 0);

    // one-bit instance
    sel         = 1'b1;
    model_lines = 16'h0000;
    pend.push_back(64'h1);
    pend.push_back(64'h0);
    pend.push_back(64'h1);
    run(100, 0);
    chk("w1_line_count", 64'(line_count1), 64'(16'd3));

    // counter wrap
    @(negedge clock);
    force dut1.line_cnt_q = 16'hFFFF;
    #1;
    release dut1.line_cnt_q;
    model_lines = 16'hFFFF;
    @(posedge clock);
    #1;
    pend.push_back(64'h0);
    run(100, 0);
    chk("wrap_line_count", 64'(line_count1), 64'(16'h0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
